// File: rtl/face_stabilizer.sv
// face_stabilizer: debounces the 3x3 face colour grid produced by the
// colour-binning stage. A face is committed only after STABLE_FRAMES
// consecutive identical, fully classified frames. Committing presents the
// face on o_face and raises o_face_new for one cycle.
//
// Transfer semantics: i_frame_done is a valid-only strobe. There is no
// ready, and the block accepts every frame_done pulse. The colour inputs
// are sampled only in a cycle with i_frame_done=1 and are ignored
// otherwise. o_face_new is a one-cycle valid pulse with no backpressure,
// and o_face holds its value until the next commit, an i_clear or an i_rst.
module face_stabilizer #(
    parameter int          STABLE_FRAMES = 4,
    parameter logic [2:0]  UNKNOWN_CODE  = 3'b111
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_color0,
    input  logic [2:0]  i_color1,
    input  logic [2:0]  i_color2,
    input  logic [2:0]  i_color3,
    input  logic [2:0]  i_color4,
    input  logic [2:0]  i_color5,
    input  logic [2:0]  i_color6,
    input  logic [2:0]  i_color7,
    input  logic [2:0]  i_color8,
    input  logic        i_frame_done,
    input  logic        i_clear,
    output logic [26:0] o_face,
    output logic        o_face_valid,
    output logic        o_face_new,
    output logic [3:0]  o_match_cnt,
    output logic [1:0]  o_state
);

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_COUNTING = 2'd1;
    localparam logic [1:0] ST_STABLE   = 2'd2;

    localparam logic [3:0] STABLE_CNT  = 4'(STABLE_FRAMES);
    localparam bit         SINGLE      = (STABLE_FRAMES == 1);

    logic [26:0] sample;
    logic [26:0] cand;
    logic [26:0] face;
    logic        face_valid;
    logic        face_new;
    logic [3:0]  cnt;
    logic [1:0]  state;
    logic        has_unknown;
    logic        same_as_cand;
    logic        differs_from_face;

    assign sample = {i_color8, i_color7, i_color6, i_color5, i_color4,
                     i_color3, i_color2, i_color1, i_color0};

    // Flag a frame that has at least one unclassified cell.
    always_comb begin
        has_unknown = 1'b0;
        for (int n = 0; n < 9; n++) begin
            if (sample[3*n +: 3] == UNKNOWN_CODE) begin
                has_unknown = 1'b1;
            end
        end
    end

    // Compare the sampled frame with the candidate and with the committed
    // face. Every commit loads the candidate from the sample, so the sample
    // is the face that would be committed.
    always_comb begin
        same_as_cand      = (sample == cand);
        differs_from_face = !face_valid || (sample != face);
    end

    // Candidate tracking, the match counter and the commit of a stable face.
    always_ff @(posedge i_clk) begin
        face_new <= 1'b0;
        if (i_rst) begin
            state      <= ST_EMPTY;
            cand       <= '0;
            cnt        <= '0;
            face       <= '0;
            face_valid <= 1'b0;
        end else if (i_clear) begin
            state      <= ST_EMPTY;
            cand       <= '0;
            cnt        <= '0;
            face       <= '0;
            face_valid <= 1'b0;
        end else if (i_frame_done) begin
            if (has_unknown) begin
                // The candidate is kept, but the frame breaks the run.
                state <= ST_EMPTY;
                cnt   <= '0;
            end else begin
                case (state)
                    ST_EMPTY: begin
                        cand <= sample;
                        cnt  <= 4'd1;
                        if (SINGLE) begin
                            state <= ST_STABLE;
                            if (differs_from_face) begin
                                face       <= sample;
                                face_valid <= 1'b1;
                                face_new   <= 1'b1;
                            end
                        end else begin
                            state <= ST_COUNTING;
                        end
                    end
                    ST_COUNTING: begin
                        if (same_as_cand) begin
                            cnt <= cnt + 4'd1;
                            if (cnt + 4'd1 == STABLE_CNT) begin
                                state <= ST_STABLE;
                                if (differs_from_face) begin
                                    face       <= sample;
                                    face_valid <= 1'b1;
                                    face_new   <= 1'b1;
                                end
                            end
                        end else begin
                            cand <= sample;
                            cnt  <= 4'd1;
                        end
                    end
                    ST_STABLE: begin
                        if (same_as_cand) begin
                            cnt <= STABLE_CNT;
                        end else begin
                            cand <= sample;
                            cnt  <= 4'd1;
                            if (SINGLE) begin
                                if (differs_from_face) begin
                                    face       <= sample;
                                    face_valid <= 1'b1;
                                    face_new   <= 1'b1;
                                end
                            end else begin
                                state <= ST_COUNTING;
                            end
                        end
                    end
                    default: begin
                        state <= ST_EMPTY;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_face       = face;
    assign o_face_valid = face_valid;
    assign o_face_new   = face_new;
    assign o_match_cnt  = cnt;
    assign o_state      = state;

endmodule

// File: tb/tb_face_stabilizer.sv
// tb_face_stabilizer: directed vectors for face_stabilizer. Two instances
// share the same inputs: dut_a uses STABLE_FRAMES=4 and dut_b uses
// STABLE_FRAMES=1.
module tb_face_stabilizer;

    localparam logic [26:0] FACE_A = 27'h0123456;
    localparam logic [26:0] FACE_B = 27'h0246801;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_done = 1'b0;
    logic        clear = 1'b0;
    logic [26:0] drv_s = '0;

    logic [26:0] a_face;
    logic        a_valid;
    logic        a_new;
    logic [3:0]  a_cnt;
    logic [1:0]  a_state;
    logic [26:0] b_face;
    logic        b_valid;
    logic        b_new;
    logic [3:0]  b_cnt;
    logic [1:0]  b_state;

    int checks = 0;
    int failures = 0;
    logic [26:0] exp_q[$];
    logic [26:0] face_a_bad;

    // clock / reset block
    always #5 clk = ~clk;

    face_stabilizer #(.STABLE_FRAMES(4)) dut_a (
        .i_clk(clk), .i_rst(rst),
        .i_color0(drv_s[2:0]),   .i_color1(drv_s[5:3]),   .i_color2(drv_s[8:6]),
        .i_color3(drv_s[11:9]),  .i_color4(drv_s[14:12]), .i_color5(drv_s[17:15]),
        .i_color6(drv_s[20:18]), .i_color7(drv_s[23:21]), .i_color8(drv_s[26:24]),
        .i_frame_done(frame_done), .i_clear(clear),
        .o_face(a_face), .o_face_valid(a_valid), .o_face_new(a_new),
        .o_match_cnt(a_cnt), .o_state(a_state)
    );

    face_stabilizer #(.STABLE_FRAMES(1)) dut_b (
        .i_clk(clk), .i_rst(rst),
        .i_color0(drv_s[2:0]),   .i_color1(drv_s[5:3]),   .i_color2(drv_s[8:6]),
        .i_color3(drv_s[11:9]),  .i_color4(drv_s[14:12]), .i_color5(drv_s[17:15]),
        .i_color6(drv_s[20:18]), .i_color7(drv_s[23:21]), .i_color8(drv_s[26:24]),
        .i_frame_done(frame_done), .i_clear(clear),
        .o_face(b_face), .o_face_valid(b_valid), .o_face_new(b_new),
        .o_match_cnt(b_cnt), .o_state(b_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one frame_done pulse, then check dut_a one step after the edge.
    task automatic send(input string tag, input logic [26:0] s, input logic [3:0] e_cnt,
                        input logic [1:0] e_st, input logic e_new);
        @(negedge clk);
        drv_s      = s;
        frame_done = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        if (e_new) exp_q.push_back(s);
        chk({tag, "_cnt"}, 32'(a_cnt), 32'(e_cnt));
        chk({tag, "_state"}, 32'(a_state), 32'(e_st));
        chk({tag, "_new"}, 32'(a_new), 32'(e_new));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard: every commit pulse from dut_a must match the next expected face.
    always @(negedge clk) begin
        if (a_new === 1'b1) begin
            if (exp_q.size() == 0) chk("spurious_commit", 32'(a_new), 32'd0);
            else chk("commit_face", 32'(a_face), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        face_a_bad = FACE_A;
        face_a_bad[14:12] = 3'b111;

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("rst_face", 32'(a_face), 32'd0);
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_new", 32'(a_new), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);
        chk("rst_state", 32'(a_state), 32'd0);

        // 1: four identical frames commit on the fourth
        send("t1_f1", FACE_A, 4'd1, 2'd1, 1'b0);
        send("t1_f2", FACE_A, 4'd2, 2'd1, 1'b0);
        send("t1_f3", FACE_A, 4'd3, 2'd1, 1'b0);
        send("t1_f4", FACE_A, 4'd4, 2'd2, 1'b1);
        chk("t1_face", 32'(a_face), 32'(FACE_A));
        chk("t1_valid", 32'(a_valid), 32'd1);
        idle(1);
        chk("t1_new_drop", 32'(a_new), 32'd0);

        // 2: after a clear, A,A,B,B,B,B commits B only on the last frame
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        chk("t2_clr_valid", 32'(a_valid), 32'd0);
        send("t2_f1", FACE_A, 4'd1, 2'd1, 1'b0);
        send("t2_f2", FACE_A, 4'd2, 2'd1, 1'b0);
        send("t2_f3", FACE_B, 4'd1, 2'd1, 1'b0);
        send("t2_f4", FACE_B, 4'd2, 2'd1, 1'b0);
        send("t2_f5", FACE_B, 4'd3, 2'd1, 1'b0);
        send("t2_f6", FACE_B, 4'd4, 2'd2, 1'b1);
        chk("t2_face", 32'(a_face), 32'(FACE_B));

        // 3: an unclassified cell rejects the frame, and the committed face is kept
        send("t3_f1", FACE_A, 4'd1, 2'd1, 1'b0);
        send("t3_f2", FACE_A, 4'd2, 2'd1, 1'b0);
        send("t3_bad", face_a_bad, 4'd0, 2'd0, 1'b0);
        chk("t3_face", 32'(a_face), 32'(FACE_B));
        chk("t3_valid", 32'(a_valid), 32'd1);

        // 4: commit A, stray to B, then relock onto A without a new pulse
        send("t4_a1", FACE_A, 4'd1, 2'd1, 1'b0);
        send("t4_a2", FACE_A, 4'd2, 2'd1, 1'b0);
        send("t4_a3", FACE_A, 4'd3, 2'd1, 1'b0);
        send("t4_a4", FACE_A, 4'd4, 2'd2, 1'b1);
        send("t4_b1", FACE_B, 4'd1, 2'd1, 1'b0);
        send("t4_b2", FACE_B, 4'd2, 2'd1, 1'b0);
        chk("t4_face_mid", 32'(a_face), 32'(FACE_A));
        send("t4_r1", FACE_A, 4'd1, 2'd1, 1'b0);
        send("t4_r2", FACE_A, 4'd2, 2'd1, 1'b0);
        send("t4_r3", FACE_A, 4'd3, 2'd1, 1'b0);
        send("t4_r4", FACE_A, 4'd4, 2'd2, 1'b0);
        chk("t4_face", 32'(a_face), 32'(FACE_A));

        // 5: the count saturates in STABLE; a clear beats a coincident frame
        send("t5_sat", FACE_A, 4'd4, 2'd2, 1'b0);
        send("t5_b1", FACE_B, 4'd1, 2'd1, 1'b0);
        @(negedge clk);
        drv_s      = FACE_B;
        frame_done = 1'b1;
        clear      = 1'b1;
        @(posedge clk);
        #1;
        frame_done = 1'b0;
        clear      = 1'b0;
        chk("t5_state", 32'(a_state), 32'd0);
        chk("t5_cnt", 32'(a_cnt), 32'd0);
        chk("t5_valid", 32'(a_valid), 32'd0);
        chk("t5_face", 32'(a_face), 32'd0);
        chk("t5_new", 32'(a_new), 32'd0);

        // 6: a reset in mid-count restarts the run; dut_b commits each differing frame
        send("t6_f1", FACE_B, 4'd1, 2'd1, 1'b0);
        send("t6_f2", FACE_B, 4'd2, 2'd1, 1'b0);
        send("t6_f3", FACE_B, 4'd3, 2'd1, 1'b0);
        pulse_reset();
        chk("t6_rst_cnt", 32'(a_cnt), 32'd0);
        chk("t6_b_rst_valid", 32'(b_valid), 32'd0);
        send("t6_f4", FACE_B, 4'd1, 2'd1, 1'b0);
        chk("t6_b1_new", 32'(b_new), 32'd1);
        chk("t6_b1_face", 32'(b_face), 32'(FACE_B));
        chk("t6_b1_state", 32'(b_state), 32'd2);
        send("t6_f5", FACE_A, 4'd1, 2'd1, 1'b0);
        chk("t6_b2_new", 32'(b_new), 32'd1);
        chk("t6_b2_face", 32'(b_face), 32'(FACE_A));
        chk("t6_b2_cnt", 32'(b_cnt), 32'd1);
        send("t6_f6", FACE_A, 4'd2, 2'd1, 1'b0);
        chk("t6_b3_new", 32'(b_new), 32'd0);
        chk("t6_b3_cnt", 32'(b_cnt), 32'd1);
        chk("t6_b3_state", 32'(b_state), 32'd2);
        send("t6_f7", FACE_B, 4'd1, 2'd1, 1'b0);
        chk("t6_b4_new", 32'(b_new), 32'd1);
        chk("t6_b4_face", 32'(b_face), 32'(FACE_B));
        chk("t6_b4_valid", 32'(b_valid), 32'd1);

        idle(2);
        chk("pending_commits", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/face_stabilizer.md
Name: face_stabilizer

Overview:
- Sits directly downstream of the colour-binning stage and consumes its nine 3-bit per-cell colour codes (3x3 face grid) once per frame.
- Commits a face only after STABLE_FRAMES consecutive identical, fully-classified frames.
- Presents the committed face plus a one-cycle "new face" strobe to later consumers (UART reporter, solver).
- Suppresses flicker from hand motion and lighting changes.

Parameters:
- STABLE_FRAMES, 4, consecutive identical frames required to commit; legal range 1..15.
- UNKNOWN_CODE, 3'b111, colour code meaning "unclassified"; any frame containing it is rejected.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous reset, active-high
- i_color0 .. i_color8  in  3 each  per-cell colour codes from the binning stage; sampled only when i_frame_done=1
- i_frame_done  in  1  one-cycle pulse; the colour inputs hold final values for the completed frame this cycle
- i_clear  in  1  one-cycle request to drop the candidate and committed face
- o_face  out  27  committed face; cell n at bits [3n+2:3n]
- o_face_valid  out  1  o_face holds a committed face
- o_face_new  out  1  one-cycle pulse: o_face just changed
- o_match_cnt  out  4  consecutive-match count of the current candidate
- o_state  out  2  0=EMPTY, 1=COUNTING, 2=STABLE

Behaviour:
Reset:
- i_rst=1 at a rising edge sets all outputs and internal registers to 0 and the state to EMPTY.
- Reset mid-count discards the candidate and any committed face.

Sampling:
- S = {i_color8, ..., i_color0} is captured only in cycles with i_frame_done=1.
- The inputs are don't-care otherwise.
- Internal candidate register C is 27 bits wide.

Rejection:
- If any cell of S equals UNKNOWN_CODE: state becomes EMPTY, o_match_cnt becomes 0, C is unchanged.
- o_face and o_face_valid are untouched on rejection.

State transitions (evaluated on i_frame_done with S fully classified):
- EMPTY: C<=S, cnt<=1. Go to STABLE if STABLE_FRAMES==1, else COUNTING.
- COUNTING, S==C: cnt<=cnt+1. If cnt+1==STABLE_FRAMES, go to STABLE.
- COUNTING, S!=C: C<=S, cnt<=1, remain COUNTING.
- STABLE, S==C: cnt saturates at STABLE_FRAMES, remain STABLE.
- STABLE, S!=C: C<=S, cnt<=1. Go to COUNTING, or stay STABLE if STABLE_FRAMES==1.

Commit:
- Trigger: the state enters STABLE or re-enters it with a new C, and either o_face_valid==0 or the new C differs from o_face.
- Action: o_face<=C, o_face_valid<=1, o_face_new=1 for exactly one cycle.
- Latency: outputs update at the clock edge that samples the qualifying i_frame_done, so they are visible the following cycle.
- Re-locking onto a face equal to o_face updates the state but produces no o_face_new.
- o_face_new is 0 in every cycle without a commit.

Clear and priority:
- i_clear=1: state EMPTY, cnt 0, o_face_valid 0, o_face 0, o_face_new 0.
- Priority order: i_rst > i_clear > i_frame_done. A frame_done coincident with i_clear is discarded.

Width rules:
- o_match_cnt never exceeds STABLE_FRAMES and never wraps.
- The S==C comparison is over all 27 bits.

Test Plan:
1. Reset, then 4 frame_done pulses with the same S=27'h0123456 (no 7s) at STABLE_FRAMES=4 -> o_match_cnt 1,2,3,4; o_face=27'h0123456, o_face_valid=1, o_face_new high one cycle after the 4th pulse only; state=2.
2. Frames A,A,B,B,B,B -> cnt 1,2,1,2,3,4; commit of B after the 6th pulse, no commit earlier.
3. Two A frames, then a frame with i_color4=3'b111 -> state 0, cnt 0, no commit; o_face keeps its prior value.
4. Face A committed; frames B,B then A,A,A,A -> A re-locks (state 2) with o_face_new never asserted; o_face stays A throughout.
5. i_clear and i_frame_done together while COUNTING -> state 0, cnt 0, o_face_valid 0, o_face 0; the coincident frame is ignored.
6. i_rst asserted after 3 matching frames, then 1 more matching frame -> cnt=1, state 1, no commit; rebuild with STABLE_FRAMES=1: every differing classified frame commits on the same edge.
